// File: rtl/peak_evt_pkg.sv
// ---------------------------------------------------------------------------
// peak_evt_pkg
// Shared types for the peak event capture slice.
//   peak_state_t : debounce FSM states (IDLE / IN_PEAK / GAP)
//   peak_evt_t   : one completed event record, 97 bits, as stored in the FIFO
//   satWidth     : clamps a 17-bit width sum into the 16-bit record field
// ---------------------------------------------------------------------------
package peak_evt_pkg;

   typedef enum logic [1:0] {
      IDLE,
      IN_PEAK,
      GAP
   } peak_state_t;

   typedef struct packed {
      logic [31:0] evtTime;
      logic [15:0] width;
      logic [15:0] peak;
      logic [15:0] ofs;
      logic [15:0] base;
      logic        forced;
   } peak_evt_t;

   // A gap absorbed near the width limit can push the sum past 16 bits;
   // the record then reports the largest representable width.
   function automatic logic [15:0] satWidth(input logic [16:0] w);
      return w[16] ? 16'hFFFF : w[15:0];
   endfunction

endpackage

// File: rtl/peak_evt_if.sv
// ---------------------------------------------------------------------------
// peak_evt_if
// Valid/ready stream carrying completed peak event records to the host.
//   master : drives evt_valid and the evt_* record fields, samples evt_ready
//   slave  : samples the record, drives evt_ready
// ---------------------------------------------------------------------------
interface peak_evt_if;

   logic        evt_valid;
   logic        evt_ready;
   logic [31:0] evt_time;
   logic [15:0] evt_width;
   logic [15:0] evt_peak;
   logic [15:0] evt_peak_ofs;
   logic [15:0] evt_base;
   logic        evt_forced;

   modport master (
      output evt_valid,
      output evt_time,
      output evt_width,
      output evt_peak,
      output evt_peak_ofs,
      output evt_base,
      output evt_forced,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_time,
      input  evt_width,
      input  evt_peak,
      input  evt_peak_ofs,
      input  evt_base,
      input  evt_forced,
      output evt_ready
   );

endinterface

// File: rtl/peak_evt_fifo.sv
// ---------------------------------------------------------------------------
// peak_evt_fifo
// Synchronous FIFO of peak_evt_t records with a registered head output.
//   clk, rst : clock, synchronous active-low reset
//   push     : write wdata; ignored when full unless a pop happens this edge
//   pop      : drop the head record; ignored when empty
//   wdata    : record to write
//   rdata    : head record, held in its own register
//   full     : DEPTH records queued
//   empty    : no record queued
//   count    : records queued
// ---------------------------------------------------------------------------
module peak_evt_fifo
   import peak_evt_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  peak_evt_t              wdata,
   output peak_evt_t              rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   peak_evt_t       r_mem [DEPTH];
   peak_evt_t       r_head;
   peak_evt_t       w_headNext;
   logic [AW-1:0]   r_rdPtr;
   logic [AW-1:0]   r_wrPtr;
   logic [AW-1:0]   w_rdPtrNext;
   logic [AW:0]     r_count;
   logic [AW:0]     w_remain;
   logic            w_doPush;
   logic            w_doPop;

   // Qualify the handshakes and work out what the head register shows after
   // this edge. When only the incoming record will be left, it bypasses the
   // array straight into the head; otherwise the head is the entry at the
   // (possibly advanced) read pointer. A push into a full FIFO is accepted
   // when a pop frees the slot on the same edge.
   always_comb begin
      w_doPop     = pop && (r_count != '0);
      w_doPush    = push && ((r_count != (AW+1)'(DEPTH)) || w_doPop);
      w_rdPtrNext = r_rdPtr + AW'(w_doPop);
      w_remain    = r_count - (AW+1)'(w_doPop);
      w_headNext  = r_head;
      if (w_remain != '0) begin
         w_headNext = r_mem[w_rdPtrNext];
      end else if (w_doPush) begin
         w_headNext = wdata;
      end
   end

   // Record storage; its contents only matter under the count, so no reset.
   always_ff @(posedge clk) begin
      if (rst && w_doPush) begin
         r_mem[r_wrPtr] <= wdata;
      end
   end

   // Pointers, occupancy and the head register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
         r_head  <= '0;
      end else begin
         r_rdPtr <= w_rdPtrNext;
         r_head  <= w_headNext;
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + AW'(1);
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign rdata = r_head;
   assign full  = (r_count == (AW+1)'(DEPTH));
   assign empty = (r_count == '0);
   assign count = r_count;

endmodule

// File: rtl/peak_event_capture.sv
// ---------------------------------------------------------------------------
// peak_event_capture
// Debounces the detector's peak flag into discrete events, measures each one
// (start index, width, signed maximum and its offset, baseline at onset) and
// queues completed records for a valid/ready consumer.
//   clk, rst         : clock, synchronous active-low reset
//   en               : sample strobe; all measurement work happens on en
//   sample           : raw sample, signed Q8.8
//   filtered_value   : detector mean, captured as the event baseline
//   peak_in          : detector peak flag
//   evt              : record stream (master side)
//   fifo_count       : records queued
//   drop_count       : records lost to a full queue, saturating
// ---------------------------------------------------------------------------
module peak_event_capture
   import peak_evt_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int MIN_GAP   = 2,
   parameter int MAX_WIDTH = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [15:0]            sample,
   input  logic [15:0]            filtered_value,
   input  logic                   peak_in,
   peak_evt_if.master             evt,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [15:0]            drop_count
);

   peak_state_t r_state;
   peak_state_t w_nextState;
   logic [31:0] r_ts;
   logic [31:0] r_start;
   logic [15:0] r_width;
   logic [15:0] r_peak;
   logic [15:0] r_ofs;
   logic [15:0] r_base;
   logic [3:0]  r_gap;
   logic [15:0] r_drop;

   logic        w_startNew;
   logic [16:0] w_widthNext;
   logic [4:0]  w_gapInc;
   logic        w_higher;
   logic [31:0] w_startNext;
   logic [15:0] w_peakNext;
   logic [15:0] w_ofsNext;
   logic [15:0] w_baseNext;
   logic        w_forceClose;
   logic        w_gapClose;
   logic        w_push;
   logic        w_pop;
   logic        w_full;
   logic        w_empty;
   peak_evt_t   w_rec;
   peak_evt_t   w_head;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state. Any flagged sample lands in IN_PEAK: either it extends the
   // open event, or the event was just force-closed and IN_PEAK with zero
   // width waits for the next flagged sample to open a fresh one.
   always_comb begin
      w_nextState = r_state;
      if (en) begin
         if (peak_in) begin
            w_nextState = IN_PEAK;
         end else begin
            case (r_state)
               IDLE:    w_nextState = IDLE;
               IN_PEAK: w_nextState = ((r_width == 16'd0) || (MIN_GAP == 1)) ? IDLE : GAP;
               GAP:     w_nextState = (w_gapInc >= 5'(MIN_GAP)) ? IDLE : GAP;
               default: w_nextState = IDLE;
            endcase
         end
      end
   end

   // Outputs of the FSM: the measurement values this sample would produce,
   // the two ways an event closes, and the record pushed on close. A gap
   // sample that is followed by more peak is folded into the width, so the
   // offset of a new maximum is always the new width minus one.
   always_comb begin
      w_startNew  = (r_state == IDLE) || ((r_state == IN_PEAK) && (r_width == 16'd0));
      w_gapInc    = {1'b0, r_gap} + 5'd1;
      w_widthNext = 17'd1;
      if (!w_startNew) begin
         if (r_state == GAP) begin
            w_widthNext = {1'b0, r_width} + {13'd0, r_gap} + 17'd1;
         end else begin
            w_widthNext = {1'b0, r_width} + 17'd1;
         end
      end
      w_higher    = $signed(sample) > $signed(r_peak);
      w_startNext = w_startNew ? r_ts : r_start;
      w_baseNext  = w_startNew ? filtered_value : r_base;
      w_peakNext  = (w_startNew || w_higher) ? sample : r_peak;
      w_ofsNext   = r_ofs;
      if (w_startNew) begin
         w_ofsNext = 16'd0;
      end else if (w_higher) begin
         w_ofsNext = w_widthNext[15:0] - 16'd1;
      end

      w_forceClose = en && peak_in && (w_widthNext >= 17'(MAX_WIDTH));
      w_gapClose   = en && !peak_in &&
                     (((r_state == IN_PEAK) && (r_width != 16'd0) && (MIN_GAP == 1)) ||
                      ((r_state == GAP) && (w_gapInc >= 5'(MIN_GAP))));
      w_push       = w_forceClose || w_gapClose;

      w_rec = '0;
      if (w_forceClose) begin
         w_rec.evtTime = w_startNext;
         w_rec.width   = satWidth(w_widthNext);
         w_rec.peak    = w_peakNext;
         w_rec.ofs     = w_ofsNext;
         w_rec.base    = w_baseNext;
         w_rec.forced  = 1'b1;
      end else begin
         w_rec.evtTime = r_start;
         w_rec.width   = r_width;
         w_rec.peak    = r_peak;
         w_rec.ofs     = r_ofs;
         w_rec.base    = r_base;
         w_rec.forced  = 1'b0;
      end
   end

   // Sample counter and measurement registers. A force-close parks the width
   // at zero so the following flagged sample restarts the measurements.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ts    <= '0;
         r_start <= '0;
         r_width <= '0;
         r_peak  <= '0;
         r_ofs   <= '0;
         r_base  <= '0;
         r_gap   <= '0;
      end else if (en) begin
         r_ts <= r_ts + 32'd1;
         if (peak_in) begin
            r_gap <= 4'd0;
            if (w_forceClose) begin
               r_width <= 16'd0;
            end else begin
               r_start <= w_startNext;
               r_width <= w_widthNext[15:0];
               r_peak  <= w_peakNext;
               r_ofs   <= w_ofsNext;
               r_base  <= w_baseNext;
            end
         end else if (r_state == IN_PEAK) begin
            r_gap <= 4'd1;
         end else if (r_state == GAP) begin
            r_gap <= w_gapInc[3:0];
         end
      end
   end

   // A record is lost only when the queue is full and nothing leaves it on
   // the same edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_drop <= '0;
      end else if (w_push && w_full && !w_pop && (r_drop != 16'hFFFF)) begin
         r_drop <= r_drop + 16'd1;
      end
   end

   assign w_pop = evt.evt_ready && !w_empty;

   peak_evt_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (evt.evt_ready),
      .wdata (w_rec),
      .rdata (w_head),
      .full  (w_full),
      .empty (w_empty),
      .count (fifo_count)
   );

   assign evt.evt_valid    = !w_empty;
   assign evt.evt_time     = w_head.evtTime;
   assign evt.evt_width    = w_head.width;
   assign evt.evt_peak     = w_head.peak;
   assign evt.evt_peak_ofs = w_head.ofs;
   assign evt.evt_base     = w_head.base;
   assign evt.evt_forced   = w_head.forced;
   assign drop_count       = r_drop;

endmodule

// File: tb/tb_peak_event_capture.sv
// ---------------------------------------------------------------------------
// tb_peak_event_capture
// Two instances share one stimulus stream: dutA closes events after two
// quiet samples, dutB after one. Both use a 4-deep queue and force-close at
// width 8. Expected records are written out by hand below.
// ---------------------------------------------------------------------------
module tb_peak_event_capture;
   import peak_evt_pkg::*;

   logic        clk;
   logic        rst;
   logic        en;
   logic [15:0] sample;
   logic [15:0] filtered_value;
   logic        peak_in;
   logic [2:0]  cntA;
   logic [2:0]  cntB;
   logic [15:0] dropA;
   logic [15:0] dropB;

   int checks;
   int errors;

   peak_evt_t expQ[$];

   typedef struct {
      bit          e;
      bit          pk;
      logic [15:0] s;
      logic [15:0] fv;
      int          cntA;
      int          cntB;
   } vec_t;

   vec_t vec[22];

   peak_evt_if evtA();
   peak_evt_if evtB();

   peak_event_capture #(.DEPTH(4), .MIN_GAP(2), .MAX_WIDTH(8)) dutA (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .sample         (sample),
      .filtered_value (filtered_value),
      .peak_in        (peak_in),
      .evt            (evtA),
      .fifo_count     (cntA),
      .drop_count     (dropA)
   );

   peak_event_capture #(.DEPTH(4), .MIN_GAP(1), .MAX_WIDTH(8)) dutB (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .sample         (sample),
      .filtered_value (filtered_value),
      .peak_in        (peak_in),
      .evt            (evtB),
      .fifo_count     (cntB),
      .drop_count     (dropB)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic peak_evt_t mkRec(input logic [31:0] t, input logic [15:0] w,
                                       input logic [15:0] p, input logic [15:0] o,
                                       input logic [15:0] b, input logic f);
      peak_evt_t r;
      r.evtTime = t;
      r.width   = w;
      r.peak    = p;
      r.ofs     = o;
      r.base    = b;
      r.forced  = f;
      return r;
   endfunction

   function automatic peak_evt_t headOf(input bit selB);
      peak_evt_t h;
      if (selB) begin
         h = mkRec(evtB.evt_time, evtB.evt_width, evtB.evt_peak,
                   evtB.evt_peak_ofs, evtB.evt_base, evtB.evt_forced);
      end else begin
         h = mkRec(evtA.evt_time, evtA.evt_width, evtA.evt_peak,
                   evtA.evt_peak_ofs, evtA.evt_base, evtA.evt_forced);
      end
      return h;
   endfunction

   function automatic logic validOf(input bit selB);
      return selB ? evtB.evt_valid : evtA.evt_valid;
   endfunction

   function automatic int countOf(input bit selB);
      return selB ? int'(cntB) : int'(cntA);
   endfunction

   task automatic setReady(input bit selB, input logic v);
      if (selB) evtB.evt_ready = v;
      else evtA.evt_ready = v;
   endtask

   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Drives one set of inputs; the caller chooses when to let the edge pass.
   task automatic applyStimulus(input logic e, input logic pk,
                                input logic [15:0] s, input logic [15:0] fv);
      en             = e;
      peak_in        = pk;
      sample         = s;
      filtered_value = fv;
   endtask

   // One strobed sample, consumed by the next rising edge.
   task automatic stepSample(input logic pk, input logic [15:0] s, input logic [15:0] fv);
      applyStimulus(1'b1, pk, s, fv);
      @(negedge clk);
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
      evtA.evt_ready = 1'b0;
      evtB.evt_ready = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Drains one instance at full rate, comparing every head against expQ,
   // then checks that the stream goes idle right after the last record.
   task automatic drainCheck(input bit selB, input string tag);
      int n;
      n = expQ.size();
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checkOutput($sformatf("%s valid%0d", tag, i), validOf(selB), 1);
         checkOutput($sformatf("%s count%0d", tag, i), countOf(selB), n - i);
         checkOutput($sformatf("%s rec%0d", tag, i), headOf(selB), expQ[i]);
         setReady(selB, 1'b1);
      end
      @(negedge clk);
      checkOutput({tag, " valid end"}, validOf(selB), 0);
      checkOutput({tag, " count end"}, countOf(selB), 0);
      setReady(selB, 1'b0);
      expQ.delete();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b0;
      evtA.evt_ready = 1'b0;
      evtB.evt_ready = 1'b0;
      applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);

      // Single event with an en=0 hold, a glitch absorbed by A but split by
      // B, and a signed maximum. Counts are checked after every edge.
      vec[0]  = '{1, 0, 16'd0,     16'h0100, 0, 0};
      vec[1]  = '{1, 1, 16'd10,    16'h0101, 0, 0};
      vec[2]  = '{1, 1, 16'd40,    16'h0102, 0, 0};
      vec[3]  = '{1, 1, 16'd70,    16'h0103, 0, 0};
      vec[4]  = '{0, 0, 16'h7FFF,  16'h0104, 0, 0};
      vec[5]  = '{1, 1, 16'd70,    16'h0105, 0, 0};
      vec[6]  = '{1, 1, 16'd20,    16'h0106, 0, 0};
      vec[7]  = '{1, 0, 16'd0,     16'h0107, 0, 1};
      vec[8]  = '{1, 0, 16'd0,     16'h0108, 1, 1};
      vec[9]  = '{1, 1, 16'd3,     16'h0202, 1, 1};
      vec[10] = '{1, 1, 16'd9,     16'h0209, 1, 1};
      vec[11] = '{1, 1, 16'd4,     16'h020A, 1, 1};
      vec[12] = '{1, 0, 16'd100,   16'h020B, 1, 2};
      vec[13] = '{1, 1, 16'd12,    16'h0303, 1, 2};
      vec[14] = '{1, 1, 16'd2,     16'h0304, 1, 2};
      vec[15] = '{1, 0, 16'd0,     16'h0305, 1, 3};
      vec[16] = '{1, 0, 16'd0,     16'h0306, 2, 3};
      vec[17] = '{1, 1, 16'h0010,  16'hFF00, 2, 3};
      vec[18] = '{1, 1, 16'hFFFF,  16'hFF01, 2, 3};
      vec[19] = '{1, 1, 16'h0010,  16'hFF02, 2, 3};
      vec[20] = '{1, 0, 16'd0,     16'h0000, 2, 4};
      vec[21] = '{1, 0, 16'd0,     16'h0000, 3, 4};

      repeat (2) @(negedge clk);
      checkOutput("reset validA", evtA.evt_valid, 0);
      checkOutput("reset countA", cntA, 0);
      checkOutput("reset dropA", dropA, 0);
      checkOutput("reset headA", headOf(1'b0), 0);
      checkOutput("reset validB", evtB.evt_valid, 0);
      rst = 1'b1;

      for (int i = 0; i < 22; i++) begin
         applyStimulus(vec[i].e, vec[i].pk, vec[i].s, vec[i].fv);
         @(negedge clk);
         checkOutput($sformatf("vec%0d countA", i), cntA, vec[i].cntA);
         checkOutput($sformatf("vec%0d countB", i), cntB, vec[i].cntB);
      end

      expQ.push_back(mkRec(32'd1,  16'd5, 16'd70,   16'd2, 16'h0101, 1'b0));
      expQ.push_back(mkRec(32'd8,  16'd6, 16'd12,   16'd4, 16'h0202, 1'b0));
      expQ.push_back(mkRec(32'd16, 16'd3, 16'h0010, 16'd0, 16'hFF00, 1'b0));
      drainCheck(1'b0, "tblA");
      expQ.push_back(mkRec(32'd1,  16'd5, 16'd70,   16'd2, 16'h0101, 1'b0));
      expQ.push_back(mkRec(32'd8,  16'd3, 16'd9,    16'd1, 16'h0202, 1'b0));
      expQ.push_back(mkRec(32'd12, 16'd2, 16'd12,   16'd0, 16'h0303, 1'b0));
      expQ.push_back(mkRec(32'd16, 16'd3, 16'h0010, 16'd0, 16'hFF00, 1'b0));
      drainCheck(1'b1, "tblB");

      // Flag held for 20 samples: two forced width-8 records, then a
      // width-4 record closed by the gap.
      doReset();
      for (int i = 0; i < 22; i++) begin
         stepSample((i < 20), 16'(i), 16'h0A00 + 16'(i));
      end
      checkOutput("force countA", cntA, 3);
      checkOutput("force dropA", dropA, 0);
      for (int k = 0; k < 2; k++) begin
         expQ.push_back(mkRec(32'd0,  16'd8, 16'd7,  16'd7, 16'h0A00, 1'b1));
         expQ.push_back(mkRec(32'd8,  16'd8, 16'd15, 16'd7, 16'h0A08, 1'b1));
         expQ.push_back(mkRec(32'd16, 16'd4, 16'd19, 16'd3, 16'h0A10, 1'b0));
         drainCheck(k == 1, (k == 1) ? "forceB" : "forceA");
      end

      // Six width-1 events into a 4-deep queue with no consumer.
      doReset();
      for (int j = 0; j < 6; j++) begin
         stepSample(1'b1, 16'h0020 + 16'(j), 16'h0B00 + 16'(j));
         stepSample(1'b0, 16'h0, 16'h0);
         stepSample(1'b0, 16'h0, 16'h0);
      end
      checkOutput("ovf countA", cntA, 4);
      checkOutput("ovf dropA", dropA, 2);
      checkOutput("ovf countB", cntB, 4);
      checkOutput("ovf dropB", dropB, 2);

      // Close a seventh event on the very edge that pops the full queue.
      stepSample(1'b1, 16'h0055, 16'h0C00);
      stepSample(1'b0, 16'h0, 16'h0);
      checkOutput("fullpop head", headOf(1'b0), mkRec(32'd0, 16'd1, 16'h0020, 16'd0, 16'h0B00, 1'b0));
      evtA.evt_ready = 1'b1;
      stepSample(1'b0, 16'h0, 16'h0);
      evtA.evt_ready = 1'b0;
      checkOutput("fullpop countA", cntA, 4);
      checkOutput("fullpop dropA", dropA, 2);
      checkOutput("fullpop dropB", dropB, 3);
      for (int j = 1; j < 4; j++) begin
         expQ.push_back(mkRec(32'(3 * j), 16'd1, 16'h0020 + 16'(j), 16'd0, 16'h0B00 + 16'(j), 1'b0));
      end
      expQ.push_back(mkRec(32'd18, 16'd1, 16'h0055, 16'd0, 16'h0C00, 1'b0));
      drainCheck(1'b0, "ovfA");

      // Reset in the middle of an open event with a record already queued.
      doReset();
      stepSample(1'b1, 16'h0033, 16'h0D00);
      stepSample(1'b0, 16'h0, 16'h0);
      stepSample(1'b0, 16'h0, 16'h0);
      checkOutput("mid pre validA", evtA.evt_valid, 1);
      stepSample(1'b1, 16'h0044, 16'h0D01);
      stepSample(1'b1, 16'h0045, 16'h0D02);
      applyStimulus(1'b1, 1'b1, 16'h0046, 16'h0D03);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("mid validA", evtA.evt_valid, 0);
      checkOutput("mid countA", cntA, 0);
      checkOutput("mid headA", headOf(1'b0), 0);
      checkOutput("mid countB", cntB, 0);
      rst = 1'b1;
      stepSample(1'b0, 16'h0, 16'h0);
      stepSample(1'b0, 16'h0, 16'h0);
      stepSample(1'b0, 16'h0, 16'h0);
      checkOutput("mid post countA", cntA, 0);
      checkOutput("mid post validA", evtA.evt_valid, 0);
      stepSample(1'b1, 16'h0066, 16'h0E00);
      stepSample(1'b0, 16'h0, 16'h0);
      stepSample(1'b0, 16'h0, 16'h0);
      expQ.push_back(mkRec(32'd3, 16'd1, 16'h0066, 16'd0, 16'h0E00, 1'b0));
      drainCheck(1'b0, "midA");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
